jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
Upstream driver stage for the jkff block. Accepts timed J/K commands over a valid/ready interface and buffers them in a small FIFO. Drives the jkff j/k inputs with each command's pair for a programmed number of clock cycles, then idles at hold (j=0, k=0). Replaces hand-written j/k stimulus with a reusable, queued command source.

Parameters:
DEPTH, 4, command FIFO depth in entries (power of two, >=2)
LEN_W, 8, width of the per-command duration field

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present on cmd_op/cmd_len
cmd_ready  output  1  FIFO can accept a command this cycle
cmd_op  input  2  00 hold (j0 k0), 01 reset (j0 k1), 10 set (j1 k0), 11 toggle (j1 k1)
cmd_len  input  LEN_W  drive duration in cycles; 0 is treated as 1
j  output  1  registered J drive to jkff
k  output  1  registered K drive to jkff
busy  output  1  high while a command is being driven
done  output  1  one-cycle pulse after the final drive cycle of each command
fifo_count  output  $clog2(DEPTH)+1  entries currently queued (excludes the active command)

Behaviour:
- Reset (async, active-high, any time): j=0, k=0, busy=0, done=0, fifo_count=0, FIFO empty, state IDLE, q_exp=0 and mismatch=0 when the optional feature is present. Reset mid-command aborts the active command and discards all queued commands.
- Handshake: cmd_ready = (fifo_count < DEPTH), combinational from registered count. A command is accepted at a rising edge with cmd_valid && cmd_ready. When not ready, cmd_valid is ignored; the command is not dropped silently, because the producer must hold it.
- FIFO: circular, with read/write pointers that wrap at DEPTH. Count logic: push only gives +1; pop only gives -1; push and pop together give an unchanged count. Pushing into an empty FIFO while popping is impossible because a pop requires a non-empty FIFO at the edge.
- FSM states:
  - IDLE: j=k=0, busy=0. If the FIFO is non-empty at an edge, pop the head, load j/k from op, set remaining = max(len,1), set busy=1, and go to DRIVE.
  - DRIVE: hold j/k. Each edge decrements remaining. At an edge where remaining==1:
    - if the FIFO is non-empty, pop the next command, load its j/k and remaining, and stay in DRIVE with no gap cycle;
    - otherwise set j=k=0 and busy=0, and go to IDLE.
- done: registered, high for exactly one cycle after each command's last drive cycle. With back-to-back commands it coincides with the first cycle of the next command.
- Latency: a command accepted at edge E0 (empty FIFO, IDLE) drives j/k from edge E1 (the next edge) for exactly max(len,1) cycles.
- Only the low LEN_W bits are used. The maximum duration is 2^LEN_W-1 cycles.

Optional Feature:
- Macro: JK_CMD_SEQUENCER_CHECK_EN.
- When defined, the block adds these ports:
  - q_in, input, 1 bit: the jkff q output.
  - q_exp, output, 1 bit: the model's expected q.
  - mismatch, output, 1 bit: sticky error flag.
- Model: q_exp updates on each edge from the registered j/k using the JK rule: 00 hold, 01 gives 0, 10 gives 1, 11 inverts. q_exp resets to 0.
- Checking: each edge sets mismatch <= mismatch | (q_in != q_exp). mismatch clears only on rst. The downstream jkff must be reset so that its q starts at 0.
- When not defined, those ports and all model logic are absent.

Test Plan:
- Reset behaviour: assert rst mid-DRIVE with 3 commands queued -> j=k=0, busy=0, fifo_count=0 immediately; after release, IDLE and no commands driven.
- Single command: push op=10, len=5 into an idle block -> j=1, k=0 for exactly 5 cycles starting the edge after accept; then j=k=0 and one done pulse.
- Back-to-back commands: push 11/len3, 01/len2, 00/len1 -> pairs 11,11,11,01,01,00 with no gaps; done pulses after cycles 3, 5 and 6; busy falls after cycle 6.
- FIFO full: hold cmd_valid high with DEPTH+2 commands while one long command is driving -> cmd_ready drops at fifo_count=4; the extra commands are accepted only after pops, in order; all commands execute in order.
- Zero length: push op=11, len=0 -> exactly 1 cycle of j=k=1, then one done pulse.
- Checker (JK_CMD_SEQUENCER_CHECK_EN): a sequence set3, toggle4, reset2 with q_in from a real jkff -> mismatch stays 0. Forcing q_in inverted for one cycle -> mismatch=1 and stays 1 until rst.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Queued J/K command driver for a downstream jkff: FIFO-buffered commands, each driven for len cycles.
// Optional q-tracking checker enabled by defining JK_CMD_SEQUENCER_CHECK_EN.
module jk_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [LEN_W-1:0]           cmd_len,
    output logic                       j,
    output logic                       k,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef JK_CMD_SEQUENCER_CHECK_EN
    ,
    input  logic                       q_in,
    output logic                       q_exp,
    output logic                       mismatch
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mem_op  [DEPTH];
    logic [LEN_W-1:0]   mem_len [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               j_d, k_d, busy_d, done_d;
    logic               push, pop, empty;
    logic [1:0]         head_op;
    logic [LEN_W-1:0]   head_len;

    assign cmd_ready = (fifo_count < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign empty     = (fifo_count == '0);
    assign head_op   = mem_op[rd_ptr];
    assign head_len  = (mem_len[rd_ptr] == '0) ? LEN_W'(1) : mem_len[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= cmd_op;
            mem_len[wr_ptr] <= cmd_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A pop on the last drive cycle loads the next command directly, so there is no idle gap.
    always_comb begin
        state_d = state_q;
        j_d     = j;
        k_d     = k;
        rem_d   = rem_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                j_d    = 1'b0;
                k_d    = 1'b0;
                busy_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    j_d     = head_op[1];
                    k_d     = head_op[0];
                    rem_d   = head_len;
                    busy_d  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (rem_q == LEN_W'(1)) begin
                    done_d = 1'b1;
                    if (!empty) begin
                        pop   = 1'b1;
                        j_d   = head_op[1];
                        k_d   = head_op[0];
                        rem_d = head_len;
                    end else begin
                        j_d     = 1'b0;
                        k_d     = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            j       <= 1'b0;
            k       <= 1'b0;
            rem_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            j       <= j_d;
            k       <= k_d;
            rem_q   <= rem_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

`ifdef JK_CMD_SEQUENCER_CHECK_EN
    // Reference jkff driven by the same registered j/k; any divergence latches until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_exp    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            mismatch <= mismatch | (q_in != q_exp);
            case ({j, k})
                2'b01:   q_exp <= 1'b0;
                2'b10:   q_exp <= 1'b1;
                2'b11:   q_exp <= ~q_exp;
                default: q_exp <= q_exp;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: reset, single, back-to-back, FIFO-full, zero-length, mid-drive reset.
// Exercises the checker ports when JK_CMD_SEQUENCER_CHECK_EN is defined.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       j, k, busy, done;
    logic [2:0] fifo_count;
`ifdef JK_CMD_SEQUENCER_CHECK_EN
    logic       q_in, q_exp, mismatch, q_ff, force_inv;
`endif

    int checks = 0;
    int errors = 0;

    logic       rec_en = 1'b0;
    logic [2:0] trace [$];
    logic [2:0] exp_trace [$];

    jk_cmd_sequencer #(.DEPTH(4), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
`ifdef JK_CMD_SEQUENCER_CHECK_EN
        ,
        .q_in       (q_in),
        .q_exp      (q_exp),
        .mismatch   (mismatch)
`endif
    );

    always #5 clk = ~clk;

`ifdef JK_CMD_SEQUENCER_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_ff <= 1'b0;
        else
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
    end
    assign q_in = q_ff ^ force_inv;
`endif

    always begin
        @(posedge clk);
        #2;
        if (rec_en)
            trace.push_back({busy, j, k});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the command until accepted; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] len);
        logic r;
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        for (int n = 0; n < 300; n++) begin
            r = cmd_ready;
            step();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", ok, 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (!busy && fifo_count == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", ok, 1);
    endtask

    task automatic push_exp(input logic [2:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            exp_trace.push_back(v);
    endtask

    initial begin
        logic [1:0] bb_jk   [7];
        logic       bb_busy [7];
        logic       bb_done [7];
        logic       ok;
        bb_jk   = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        bb_busy = '{1, 1, 1, 1, 1, 1, 0};
        bb_done = '{0, 0, 0, 1, 0, 1, 1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_len = 8'd0;
`ifdef JK_CMD_SEQUENCER_CHECK_EN
        force_inv = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", cmd_ready, 1);
        rst = 1'b0;
        step();

        // Single command: set for 5 cycles.
        send(2'b10, 8'd5);
        cmd_valid = 1'b0;
        check("single_acc_count", fifo_count, 1);
        check("single_acc_j", j, 0);
        check("single_acc_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("single_jk", {j, k}, 2'b10);
            check("single_busy", busy, 1);
            check("single_done", done, 0);
        end
        step();
        check("single_end_jk", {j, k}, 2'b00);
        check("single_end_busy", busy, 0);
        check("single_end_done", done, 1);
        step();
        check("single_done_clr", done, 0);

        // Back-to-back: 11/3, 01/2, 00/1.
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_len = 8'd3;
        step();
        cmd_op = 2'b01;
        cmd_len = 8'd2;
        for (int i = 0; i < 7; i++) begin
            step();
            check("b2b_jk", {j, k}, bb_jk[i]);
            check("b2b_busy", busy, bb_busy[i]);
            check("b2b_done", done, bb_done[i]);
            if (i == 0) begin
                cmd_op = 2'b00;
                cmd_len = 8'd1;
            end
            if (i == 1)
                cmd_valid = 1'b0;
        end
        step();
        check("b2b_done_clr", done, 0);
        step();

        // FIFO full: long command then DEPTH+2 commands with valid held.
        exp_trace.delete();
        trace.delete();
        exp_trace.push_back(3'b000);
        push_exp(3'b110, 12);
        push_exp(3'b111, 2);
        push_exp(3'b101, 1);
        push_exp(3'b110, 3);
        push_exp(3'b100, 2);
        push_exp(3'b111, 1);
        push_exp(3'b101, 2);
        exp_trace.push_back(3'b000);
        send(2'b10, 8'd12);
        rec_en = 1'b1;
        send(2'b11, 8'd2);
        send(2'b01, 8'd1);
        send(2'b10, 8'd3);
        send(2'b00, 8'd2);
        check("full_count", fifo_count, 4);
        check("full_ready", cmd_ready, 0);
        send(2'b11, 8'd1);
        send(2'b01, 8'd2);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (trace.size() >= exp_trace.size()) begin
                ok = 1'b1;
                break;
            end
        end
        rec_en = 1'b0;
        check("full_trace_wait", ok, 1);
        for (int i = 0; i < exp_trace.size(); i++)
            if (i < trace.size())
                check("full_trace", trace[i], exp_trace[i]);
        wait_idle();

        // Zero length behaves as one cycle.
        send(2'b11, 8'd0);
        cmd_valid = 1'b0;
        step();
        check("zero_jk", {j, k}, 2'b11);
        check("zero_busy", busy, 1);
        step();
        check("zero_end_jk", {j, k}, 2'b00);
        check("zero_end_busy", busy, 0);
        check("zero_done", done, 1);
        step();
        check("zero_done_clr", done, 0);

        // Asynchronous reset mid-drive with three commands queued.
        send(2'b10, 8'd50);
        send(2'b01, 8'd4);
        send(2'b11, 8'd4);
        send(2'b00, 8'd4);
        cmd_valid = 1'b0;
        check("mid_count", fifo_count, 3);
        check("mid_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_jk", {j, k}, 2'b00);
        check("arst_busy", busy, 0);
        check("arst_count", fifo_count, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_jk", {j, k}, 2'b00);
            check("post_rst_busy", busy, 0);
            check("post_rst_count", fifo_count, 0);
        end

`ifdef JK_CMD_SEQUENCER_CHECK_EN
        // Checker: set3, toggle4, reset2 against a real jkff, then one forced bad cycle.
        send(2'b10, 8'd3);
        send(2'b11, 8'd4);
        send(2'b01, 8'd2);
        cmd_valid = 1'b0;
        wait_idle();
        step();
        check("chk_mismatch_clean", mismatch, 0);
        check("chk_q_exp", q_exp, 0);
        force_inv = 1'b1;
        step();
        force_inv = 1'b0;
        check("chk_mismatch_set", mismatch, 1);
        step();
        step();
        check("chk_mismatch_sticky", mismatch, 1);
        rst = 1'b1;
        #1;
        check("chk_mismatch_rst", mismatch, 0);
        step();
        rst = 1'b0;
        step();
        check("chk_mismatch_after_rst", mismatch, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
